// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: video reads always win the single-port ROM, and host reads fill the idle cycles.
// If video blocks a pending host read for HOST_TIMEOUT cycles, the host request is aborted with an error.
module font_rom_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 8,
  parameter int HOST_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vid_rd_i,
  input  logic [ADDR_WIDTH-1:0] vid_addr_i,
  output logic [DATA_WIDTH-1:0] vid_data_o,
  output logic                  vid_valid_o,
  input  logic                  host_req_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  output logic                  host_ready_o,
  output logic [DATA_WIDTH-1:0] host_data_o,
  output logic                  host_valid_o,
  output logic                  host_err_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i
);

  localparam int CNT_W = $clog2(HOST_TIMEOUT) + 1;

  // state | meaning
  // IDLE  | ready to accept a host request
  // PEND  | host request latched, waiting for a cycle without video
  // WAIT  | host read issued to ROM, data returns through the tag pipe
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_HOST} owner_t;

  state_t                  state_q, state_d;
  owner_t                  own_q, own_d;
  logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    grant_host;
  logic                    timeout;

  logic [DATA_WIDTH-1:0]   vid_data_q;
  logic                    vid_valid_q;
  logic [DATA_WIDTH-1:0]   host_data_q;
  logic                    host_valid_q;
  logic                    host_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      own_q      <= OWN_NONE;
      haddr_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      haddr_q    <= haddr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    wait_cnt_d   = wait_cnt_q;
    grant_host   = 1'b0;
    timeout      = 1'b0;
    host_ready_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        host_ready_o = 1'b1;
        if (host_req_i) begin
          haddr_d    = host_addr_i;
          wait_cnt_d = '0;
          state_d    = S_PEND;
        end
      end
      S_PEND: begin
        if (!vid_rd_i) begin
          grant_host = 1'b1;
          state_d    = S_WAIT;
        end else if (wait_cnt_q == CNT_W'(HOST_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // When nobody reads, the video address still drives the ROM; that read is discarded.
  assign rom_addr_o = grant_host ? haddr_q : vid_addr_i;

  always_comb begin
    own_d = OWN_NONE;
    if (vid_rd_i)        own_d = OWN_VID;
    else if (grant_host) own_d = OWN_HOST;
  end

  // Second pipe stage: the ROM word shows up one cycle after issue and goes to its owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vid_data_q   <= '0;
      vid_valid_q  <= 1'b0;
      host_data_q  <= '0;
      host_valid_q <= 1'b0;
      host_err_q   <= 1'b0;
    end else begin
      vid_valid_q  <= (own_q == OWN_VID);
      host_valid_q <= (own_q == OWN_HOST) || timeout;
      host_err_q   <= timeout;
      if (own_q == OWN_VID)
        vid_data_q <= rom_data_i;
      if (own_q == OWN_HOST)
        host_data_q <= rom_data_i;
      else if (timeout)
        host_data_q <= '0;
    end
  end

  assign vid_data_o   = vid_data_q;
  assign vid_valid_o  = vid_valid_q;
  assign host_data_o  = host_data_q;
  assign host_valid_o = host_valid_q;
  assign host_err_o   = host_err_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed scenarios, then randomized traffic.
// A cycle-indexed schedule of expected responses acts as the reference model.
module tb_font_rom_arbiter;

  localparam int AW   = 11;
  localparam int DW   = 8;
  localparam int TMO  = 8;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_rd;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic          host_ready;
  logic [DW-1:0] host_data;
  logic          host_valid;
  logic          host_err;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  font_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOST_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .vid_rd_i(vid_rd), .vid_addr_i(vid_addr), .vid_data_o(vid_data), .vid_valid_o(vid_valid),
    .host_req_i(host_req), .host_addr_i(host_addr), .host_ready_o(host_ready),
    .host_data_o(host_data), .host_valid_o(host_valid), .host_err_o(host_err),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  // The upper address bits are folded into the word so that the bench sees a wrong high address.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return a[7:0] ^ {a[10:8], 5'b0};
  endfunction

  always_ff @(posedge clk) rom_data <= rom_word(rom_addr);

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Each cycle has an optional expected video response and an optional expected host response.
  bit          s_vv [MAXC+4];
  bit [DW-1:0] s_vd [MAXC+4];
  bit          s_hv [MAXC+4];
  bit          s_he [MAXC+4];
  bit [DW-1:0] s_hd [MAXC+4];

  bit          hbusy = 0;
  bit          granted = 0;
  int          acc_c = 0;
  int          free_at = 0;
  int          blocked = 0;
  bit [AW-1:0] hm_addr = '0;
  bit [DW-1:0] cur_vd = '0;
  bit [DW-1:0] cur_hd = '0;

  task automatic step(input logic r, input logic v, input logic [AW-1:0] va,
                      input logic hr, input logic [AW-1:0] ha);
    bit          e_vv, e_hv, e_he, e_rdy, pend;
    bit [AW-1:0] e_rom;
    int          c;
    c = cyc;
    if (c >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", c, MAXC);
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "cycle budget exceeded");
    end
    rst = r; vid_rd = v; vid_addr = va; host_req = hr; host_addr = ha;
    #1;
    pend = 0;
    if (r) begin
      for (int k = c; k < c + 4; k++) begin
        s_vv[k] = 0; s_hv[k] = 0; s_he[k] = 0;
      end
      hbusy = 0; cur_vd = '0; cur_hd = '0;
      e_vv = 0; e_hv = 0; e_he = 0; e_rdy = 1; e_rom = va;
    end else begin
      if (hbusy && c == free_at) hbusy = 0;
      e_vv = s_vv[c];
      if (e_vv) cur_vd = s_vd[c];
      e_hv = s_hv[c];
      e_he = s_he[c];
      if (e_hv) cur_hd = s_hd[c];
      pend  = hbusy && !granted && (c > acc_c);
      e_rdy = !hbusy;
      e_rom = (!v && pend) ? hm_addr : va;
    end
    check_val("vid_valid",  vid_valid,  e_vv);
    check_val("vid_data",   vid_data,   cur_vd);
    check_val("host_valid", host_valid, e_hv);
    check_val("host_data",  host_data,  cur_hd);
    check_val("host_ready", host_ready, e_rdy);
    check_val("rom_addr",   rom_addr,   e_rom);
    if (e_hv) check_val("host_err", host_err, e_he);
    if (!r) begin
      if (v) begin
        s_vv[c+2] = 1; s_vd[c+2] = rom_word(va);
      end
      if (pend) begin
        if (!v) begin
          granted = 1; free_at = c + 2;
          s_hv[c+2] = 1; s_he[c+2] = 0; s_hd[c+2] = rom_word(hm_addr);
        end else begin
          blocked++;
          if (blocked == TMO) begin
            granted = 1; free_at = c + 1;
            s_hv[c+1] = 1; s_he[c+1] = 1; s_hd[c+1] = '0;
          end
        end
      end
      if (e_rdy && hr) begin
        hbusy = 1; granted = 0; acc_c = c; blocked = 0; hm_addr = ha; free_at = -1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, AW'(i * 37), 0, '0);
  endtask

  initial begin
    rst = 1; vid_rd = 0; vid_addr = '0; host_req = 0; host_addr = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 11'h155);
    idle(2);
    // video burst at 0x041..0x044
    for (int i = 0; i < 4; i++) step(0, 1, AW'(11'h041 + i), 0, '0);
    idle(3);
    // host read on an idle ROM
    step(0, 0, '0, 1, 11'h7F0);
    idle(4);
    // host blocked for 5 cycles and then served
    step(0, 0, '0, 1, 11'h123);
    for (int i = 0; i < 5; i++) step(0, 1, AW'(11'h200 + i), 0, '0);
    idle(4);
    // continuous video forces a timeout
    step(0, 0, '0, 1, 11'h555);
    for (int i = 0; i < 12; i++) step(0, 1, AW'(11'h600 + i), 0, '0);
    idle(3);
    // host request held high, so requests run back to back
    for (int i = 0; i < 10; i++) step(0, 0, '0, 1, AW'(11'h300 + i * 5));
    idle(3);
    // reset one cycle after a host grant
    step(0, 0, '0, 1, 11'h0AA);
    step(0, 0, '0, 0, '0);
    step(1, 0, '0, 0, '0);
    idle(4);
    // reset one cycle after a video read, with a pending host request dropped
    step(0, 0, '0, 1, 11'h4C4);
    step(0, 1, 11'h0C3, 0, '0);
    step(1, 1, 11'h0C4, 1, 11'h111);
    idle(4);
    // randomized traffic
    begin
      int mode;
      mode = 0;
      for (int i = 0; i < 2400; i++) begin
        logic r, v, hr;
        if (i % 48 == 0) mode = int'($urandom_range(0, 3));
        case (mode)
          0:       v = ($urandom_range(0, 3) == 0);
          1:       v = ($urandom_range(0, 9) != 0);
          2:       v = 1'b1;
          default: v = 1'b0;
        endcase
        hr = $urandom_range(0, 1) == 1;
        r  = ($urandom_range(0, 299) == 0);
        step(r, v, AW'($urandom), hr, AW'($urandom));
      end
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/font_rom_arbiter.md
# font_rom_arbiter

Arbiter for the single-port, registered-output font ROM in the On-Screen Display core. It shares the ROM between two requesters. The video pixel pipeline gets absolute priority and is never stalled. A host (bus-side glyph read/debug) requester is served in idle ROM cycles through a ready/valid handshake with a starvation timeout. It sits between the OSD text pipeline, the bus-side glyph reader and the font ROM instance.

## Interface

- ADDR_WIDTH, 11, font ROM address width (128 chars x 16 rows)
- DATA_WIDTH, 8, font ROM word width (one glyph row)
- HOST_TIMEOUT, 1024, maximum number of host-blocked cycles before the request is aborted with error; must be >= 1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vid_rd  in  1  video read request this cycle (highest priority)
- vid_addr  in  ADDR_WIDTH  video read address
- vid_data  out  DATA_WIDTH  video read data
- vid_valid  out  1  vid_data valid, one-cycle pulse per vid_rd
- host_req  in  1  host read request
- host_addr  in  ADDR_WIDTH  host read address, sampled on accept
- host_ready  out  1  host request can be accepted this cycle
- host_data  out  DATA_WIDTH  host read data (0 on error)
- host_valid  out  1  host response pulse, one cycle
- host_err  out  1  qualifies host_valid: response is a timeout abort
- rom_addr  out  ADDR_WIDTH  address to font ROM (combinational)
- rom_data  in  DATA_WIDTH  font ROM output; valid the cycle after rom_addr is presented

## Operation

- Host FSM states: IDLE, PEND, WAIT.
- IDLE: host_ready=1. On host_req=1, latch host_addr into haddr, clear wait_cnt, and go to PEND. Accepting a request never grants the ROM in the same cycle.
- PEND: host_ready=0.
  - If vid_rd=0, the host is granted: rom_addr=haddr, go to WAIT.
  - If vid_rd=1 and wait_cnt==HOST_TIMEOUT-1, go to IDLE and register host_valid=1, host_err=1, host_data=0 for the next cycle.
  - If vid_rd=1 otherwise, increment wait_cnt.
- WAIT: host_ready=0. Go to IDLE unconditionally. The ROM output is captured as described under the read pipeline.
- rom_addr mux, priority order:
  - vid_rd=1 → vid_addr
  - else state==PEND → haddr
  - else vid_addr (don't-care read, no valid generated)
- Read pipeline: a 2-stage owner tag (none/video/host) follows each granted read.
  - Stage-2 video: vid_data<=rom_data, vid_valid<=1.
  - Stage-2 host: host_data<=rom_data, host_valid<=1, host_err<=0.
  - Otherwise the valid outputs are 0 and the data registers hold their value.
- vid_valid and host_valid can never be 1 in the same cycle as a result of normal reads. A host timeout response may coincide with a vid_valid pulse; this is legal.
- The video path is fully pipelined: back-to-back vid_rd every cycle gives back-to-back vid_valid.

## Timing

- Video latency: vid_rd at cycle N → vid_valid and vid_data in cycle N+2. Fixed; host activity has no effect.
- Host latency, measured from the accept cycle A (host_req & host_ready):
  - Earliest grant is A+1.
  - Response is at grant cycle G+2.
  - Minimum is A+3.
  - host_ready is 1 again at G+2, so a new request may be accepted in the response cycle.
- Timeout response: appears the cycle after the HOST_TIMEOUT-th consecutive blocked PEND cycle, i.e. A+HOST_TIMEOUT+1 when video blocks continuously from A+1. host_ready=1 in that same cycle.
- wait_cnt holds its value through non-blocked cycles (there are none in PEND; granting exits PEND). Width is clog2(HOST_TIMEOUT)+1.
- host_req while host_ready=0 is ignored. It is not queued, and the host must hold it.
- Reset values:
  - state=IDLE, so host_ready=1 while reset is asserted; requests are ignored during reset.
  - vid_valid, host_valid, host_err, vid_data, host_data, wait_cnt and haddr are all 0.
  - Owner tags are none.
- Reset mid-operation: in-flight owner tags are cleared. A read granted before reset produces no valid pulse after reset release, and a pending host request is dropped.

## Test plan

- Video stream: vid_rd=1 for 4 cycles at 0x041..0x044, ROM preloaded with word=addr[7:0] → vid_valid for 4 consecutive cycles starting 2 cycles later, data 0x41..0x44.
- Host idle grant: host_req at A with addr 0x7F0 while vid_rd=0 → host_ready=0 at A+1, host_valid=1, host_err=0, host_data=0xF0 at A+3, host_ready=1 at A+3.
- Host blocked then served: HOST_TIMEOUT=8, vid_rd=1 for 5 cycles after accept, then 0 → grant on the first idle cycle, response 2 cycles later, err=0, video data unaffected.
- Timeout: HOST_TIMEOUT=8, vid_rd held 1 → host_valid=1, host_err=1, host_data=0 at A+9; state IDLE; video responses remain continuous.
- Back-to-back host: re-assert host_req in the response cycle → accepted there, second response 3 cycles later, no lost or duplicate valid pulses.
- Reset mid-read: assert reset in cycle G+1 of a host grant and in cycle N+1 of a video read → no host_valid or vid_valid after release, host_ready=1, all outputs 0.
